fc_argmax: RTL and testbench



---
 rtl/fc_pkg.sv | 13 +
 rtl/argmax_cmp.sv | 13 +
 rtl/fc_argmax.sv | 100 ++++++++++
 tb/tb_fc_argmax.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the fully-connected classification head.
package fc_pkg;

  localparam int FC_SCORE_W     = 38;
  localparam int FC_NUM_CLASSES = 10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } argmax_state_t;

endpackage

// File: rtl/argmax_cmp.sv
// Signed greater-than between an incoming score and the current best.
module argmax_cmp #(
  parameter int SCORE_W = 38
) (
  input  logic [SCORE_W-1:0] i_score,
  input  logic [SCORE_W-1:0] i_best,
  output logic               o_gt
);

  // Strict compare keeps the earlier (lower) index on ties.
  assign o_gt = $signed(i_score) > $signed(i_best);

endmodule

// File: rtl/fc_argmax.sv
// Streaming argmax over NUM_CLASSES signed scores with a valid/ready result.
module fc_argmax
  import fc_pkg::*;
#(
  parameter int NUM_CLASSES = FC_NUM_CLASSES,
  parameter int SCORE_W     = FC_SCORE_W,
  parameter int IDX_W       = $clog2(NUM_CLASSES)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [SCORE_W-1:0] in_data,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [IDX_W-1:0]   out_class,
  output logic [SCORE_W-1:0] out_score,
  output logic               out_err,
  output logic               busy
);

  argmax_state_t r_state;
  argmax_state_t w_state_next;

  logic [IDX_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_best_idx;
  logic [SCORE_W-1:0] r_best_score;
  logic               r_err;

  logic w_gt;
  logic w_accept;
  logic w_last_beat;
  logic w_replace;
  logic w_clear;

  argmax_cmp #(
    .SCORE_W (SCORE_W)
  ) u_cmp (
    .i_score (in_data),
    .i_best  (r_best_score),
    .o_gt    (w_gt)
  );

  assign w_accept    = in_valid && (r_state == COLLECT);
  assign w_last_beat = (r_cnt == IDX_W'(NUM_CLASSES - 1));
  assign w_replace   = w_accept && ((r_cnt == '0) || w_gt);
  assign w_clear     = (r_state == IDLE) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = COLLECT;
      COLLECT: if (w_accept && w_last_beat) w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_err        <= 1'b0;
    end else if (w_clear) begin
      r_cnt        <= '0;
      r_best_idx   <= '0;
      r_best_score <= '0;
      r_err        <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
      if (w_replace) begin
        r_best_idx   <= r_cnt;
        r_best_score <= in_data;
      end
      // Flag in_last on the wrong beat, or missing on the final beat.
      if (in_last != w_last_beat) begin
        r_err <= 1'b1;
      end
    end
  end

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign out_class = r_best_idx;
  assign out_score = r_best_score;
  assign out_err   = r_err;

endmodule

// File: tb/tb_fc_argmax.sv
// Directed self-checking bench for fc_argmax.
module tb_fc_argmax;

  localparam int N  = 10;
  localparam int SW = 38;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SW-1:0] in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_class;
  logic [SW-1:0] out_score;
  logic          out_err;
  logic          busy;

  int n_tests = 0;
  int n_fail  = 0;

  logic [SW-1:0] s [N];

  always #5 clk = ~clk;

  fc_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_score (out_score),
    .out_err   (out_err),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [SW-1:0] d, input logic last);
    in_valid = 1'b1; in_data = d; in_last = last;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic run_all(input int last_beat);
    for (int i = 0; i < N; i++) send(s[i], (i == last_beat));
  endtask

  task automatic check_result(input string tag, input int cls,
                              input logic [SW-1:0] score, input logic err);
    chk({tag, "_valid"}, 64'(out_valid), 64'(1));
    chk({tag, "_class"}, 64'(out_class), 64'(cls));
    chk({tag, "_score"}, 64'(out_score), 64'(score));
    chk({tag, "_err"},   64'(out_err),   64'(err));
    $display("[TB] %s class=%0d score=%0h err=%0b", tag, out_class, out_score, out_err);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_hs_valid"}, 64'(out_valid), 64'(0));
    chk({tag, "_hs_busy"},  64'(busy),      64'(0));
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_in_ready",  64'(in_ready),  64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_class",     64'(out_class), 64'(0));
    chk("rst_score",     64'(out_score), 64'(0));
    chk("rst_err",       64'(out_err),   64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Basic run: max 12 at index 2
    do_start();
    chk("t1_in_ready", 64'(in_ready), 64'(1));
    s = '{38'sd5, -38'sd3, 38'sd12, 38'sd7, 38'sd0, 38'sd1, 38'sd2, 38'sd3, 38'sd4, 38'sd11};
    run_all(9);
    check_result("t1", 2, 38'd12, 1'b0);
    chk("t1_in_ready_done", 64'(in_ready), 64'(0));
    handshake("t1");

    // All most-negative: tie keeps index 0
    do_start();
    for (int i = 0; i < N; i++) s[i] = 38'h20_0000_0000;
    run_all(9);
    check_result("t2", 0, 38'h20_0000_0000, 1'b0);
    handshake("t2");

    // Tie 9 at indices 3 and 7
    do_start();
    for (int i = 0; i < N; i++) s[i] = '0;
    s[3] = 38'd9; s[7] = 38'd9;
    run_all(9);
    check_result("t3", 3, 38'd9, 1'b0);
    handshake("t3");

    // Index 7 = 10 with in_valid gaps and start pulses mid-COLLECT
    do_start();
    s[7] = 38'd10;
    for (int i = 0; i < N; i++) begin
      send(s[i], (i == 9));
      if (i < 9) begin
        start = (i == 4);
        @(posedge clk); @(negedge clk);
        start = 1'b0;
      end
    end
    check_result("t4", 7, 38'd10, 1'b0);
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      @(posedge clk); @(negedge clk);
      start = 1'b0;
      check_result($sformatf("t4_hold%0d", c), 7, 38'd10, 1'b0);
    end
    // start coinciding with the DONE handshake is ignored
    start = 1'b1;
    handshake("t4");
    start = 1'b0;
    chk("t4_ignored_start", 64'(in_ready), 64'(0));

    // Misplaced in_last on beat 4: still 10 beats, err set
    @(negedge clk);
    do_start();
    for (int i = 0; i < N; i++) s[i] = 38'(i * 3);
    for (int i = 0; i < N - 1; i++) send(s[i], (i == 4));
    chk("t5_not_done_early", 64'(out_valid), 64'(0));
    chk("t5_busy", 64'(busy), 64'(1));
    send(s[9], 1'b0);
    check_result("t5", 9, 38'd27, 1'b1);
    handshake("t5");

    // Following clean run clears err
    do_start();
    run_all(9);
    check_result("t6", 9, 38'd27, 1'b0);
    handshake("t6");

    // Reset mid-COLLECT after beat 6
    do_start();
    for (int i = 0; i < N; i++) s[i] = '0;
    s[2] = 38'd1000;
    for (int i = 0; i < 7; i++) send(s[i], 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t7_rst_in_ready",  64'(in_ready),  64'(0));
    chk("t7_rst_out_valid", 64'(out_valid), 64'(0));
    chk("t7_rst_class",     64'(out_class), 64'(0));
    chk("t7_rst_score",     64'(out_score), 64'(0));
    chk("t7_rst_busy",      64'(busy),      64'(0));
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    do_start();
    for (int i = 0; i < N; i++) s[i] = 38'(i);
    s[5] = 38'd50;
    run_all(9);
    check_result("t7", 5, 38'd50, 1'b0);
    handshake("t7");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
